// File: rtl/issue_queue_integer_if.sv
// Dispatch, CDB and issue bundle of the integer issue queue.
// master = dispatch/CDB/execution-unit side, slave = the queue itself.
interface issue_queue_integer_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_WIDTH    = 6,
   parameter int OPCODE_WIDTH = 4
);
   logic                    dispatch_en_integer;
   logic [OPCODE_WIDTH-1:0] dispatch_opcode;
   logic [TAG_WIDTH-1:0]    dispatch_rd_tag;
   logic [DATA_WIDTH-1:0]   dispatch_rs1_data;
   logic [TAG_WIDTH-1:0]    dispatch_rs1_tag;
   logic                    dispatch_rs1_valid;
   logic [DATA_WIDTH-1:0]   dispatch_rs2_data;
   logic [TAG_WIDTH-1:0]    dispatch_rs2_tag;
   logic                    dispatch_rs2_valid;
   logic [TAG_WIDTH-1:0]    CDB_tag;
   logic [DATA_WIDTH-1:0]   CDB_data;
   logic                    CDB_valid;
   logic                    issue_ready;
   logic                    issueque_full_integer;
   logic                    issue_valid;
   logic [OPCODE_WIDTH-1:0] issue_opcode;
   logic [TAG_WIDTH-1:0]    issue_rd_tag;
   logic [DATA_WIDTH-1:0]   issue_rs1_data;
   logic [DATA_WIDTH-1:0]   issue_rs2_data;

   modport master (
      output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
             dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
             dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
             CDB_tag, CDB_data, CDB_valid, issue_ready,
      input  issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
             issue_rs1_data, issue_rs2_data
   );

   modport slave (
      input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
             dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
             dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
             CDB_tag, CDB_data, CDB_valid, issue_ready,
      output issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
             issue_rs1_data, issue_rs2_data
   );
endinterface

// File: rtl/issue_queue_integer.sv
// Integer reservation station: age-ordered collapsing queue with CDB wakeup and oldest-ready issue.
// Optional macro IQ_WAKEUP_BYPASS_EN enables zero-cycle wakeup-to-issue from the CDB.
module issue_queue_integer #(
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_WIDTH    = 6,
   parameter int OPCODE_WIDTH = 4,
   parameter int DEPTH        = 4
) (
   input logic                 clk,
   input logic                 reset,
   issue_queue_integer_if.slave iq
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] opcode;
      logic [TAG_WIDTH-1:0]    rd_tag;
      logic [TAG_WIDTH-1:0]    rs1_tag;
      logic [DATA_WIDTH-1:0]   rs1_data;
      logic                    rs1_valid;
      logic [TAG_WIDTH-1:0]    rs2_tag;
      logic [DATA_WIDTH-1:0]   rs2_data;
      logic                    rs2_valid;
   } entry_t;

   entry_t         slot_r [DEPTH];
   logic [CW-1:0]  count_r;

   entry_t         wake_s [DEPTH];
   entry_t         up_s   [DEPTH];
   entry_t         nx_s   [DEPTH];
   entry_t         in_s;
   entry_t         sel_s;
   logic [DEPTH-1:0] occ_s;
   logic [DEPTH-1:0] ready_s;
   logic           found_s;
   logic [CW-1:0]  sel_idx_s;
   logic           full_s;
   logic           fire_s;
   logic           accept_s;
   logic [CW-1:0]  wpos_s;
   logic [CW-1:0]  count_nx_s;

   // Latch broadcast data into any waiting operand whose producer tag matches.
   function automatic entry_t snoop(input entry_t e, input logic cdb_valid,
                                    input logic [TAG_WIDTH-1:0] cdb_tag,
                                    input logic [DATA_WIDTH-1:0] cdb_data);
      entry_t r;
      r = e;
      if (cdb_valid && !e.rs1_valid && (e.rs1_tag == cdb_tag)) begin
         r.rs1_valid = 1'b1;
         r.rs1_data  = cdb_data;
      end else begin
         r.rs1_valid = e.rs1_valid;
      end
      if (cdb_valid && !e.rs2_valid && (e.rs2_tag == cdb_tag)) begin
         r.rs2_valid = 1'b1;
         r.rs2_data  = cdb_data;
      end else begin
         r.rs2_valid = e.rs2_valid;
      end
      return r;
   endfunction

   // Occupancy and post-wakeup view of every slot and of the incoming op.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         occ_s[i] = (CW'(i) < count_r);
         if (occ_s[i]) begin
            wake_s[i] = snoop(slot_r[i], iq.CDB_valid, iq.CDB_tag, iq.CDB_data);
         end else begin
            wake_s[i] = slot_r[i];
         end
      end
      in_s.opcode    = iq.dispatch_opcode;
      in_s.rd_tag    = iq.dispatch_rd_tag;
      in_s.rs1_tag   = iq.dispatch_rs1_tag;
      in_s.rs1_data  = iq.dispatch_rs1_data;
      in_s.rs1_valid = iq.dispatch_rs1_valid;
      in_s.rs2_tag   = iq.dispatch_rs2_tag;
      in_s.rs2_data  = iq.dispatch_rs2_data;
      in_s.rs2_valid = iq.dispatch_rs2_valid;
      in_s = snoop(in_s, iq.CDB_valid, iq.CDB_tag, iq.CDB_data);
   end

`ifdef IQ_WAKEUP_BYPASS_EN
   // A broadcast in this cycle already counts as a ready operand.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_s[i] = occ_s[i] & wake_s[i].rs1_valid & wake_s[i].rs2_valid;
      end
   end
`else
   // Only operands latched at a previous edge count as ready.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_s[i] = occ_s[i] & slot_r[i].rs1_valid & slot_r[i].rs2_valid;
      end
   end
`endif

   // Oldest-first select; woken data is used so a bypassed operand carries CDB_data.
   always_comb begin
      found_s   = 1'b0;
      sel_idx_s = {CW{1'b0}};
      sel_s     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready_s[i] && !found_s) begin
            found_s   = 1'b1;
            sel_idx_s = CW'(i);
            sel_s     = wake_s[i];
         end else begin
            found_s   = found_s;
         end
      end
   end

   assign iq.issue_valid           = found_s;
   assign iq.issue_opcode          = sel_s.opcode;
   assign iq.issue_rd_tag          = sel_s.rd_tag;
   assign iq.issue_rs1_data        = sel_s.rs1_data;
   assign iq.issue_rs2_data        = sel_s.rs2_data;
   assign iq.issueque_full_integer = full_s;

   // Collapse on issue, append on dispatch; full is checked before the issue frees a slot.
   always_comb begin
      full_s     = (count_r == CW'(DEPTH));
      fire_s     = found_s & iq.issue_ready;
      accept_s   = iq.dispatch_en_integer & ~full_s;
      wpos_s     = count_r - {{(CW-1){1'b0}}, fire_s};
      count_nx_s = wpos_s + {{(CW-1){1'b0}}, accept_s};
      for (int i = 0; i < DEPTH - 1; i++) begin
         up_s[i] = wake_s[i+1];
      end
      up_s[DEPTH-1] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (accept_s && (CW'(i) == wpos_s)) begin
            nx_s[i] = in_s;
         end else if (fire_s && (CW'(i) >= sel_idx_s)) begin
            nx_s[i] = up_s[i];
         end else begin
            nx_s[i] = wake_s[i];
         end
         if (CW'(i) >= count_nx_s) begin
            nx_s[i].rs1_valid = 1'b0;
            nx_s[i].rs2_valid = 1'b0;
         end else begin
            nx_s[i] = nx_s[i];
         end
      end
   end

   // Queue state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= '0;
         end
      end else begin
         count_r <= count_nx_s;
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= nx_s[i];
         end
      end
   end
endmodule

// File: tb/tb_issue_queue_integer.sv
// Self-checking bench for issue_queue_integer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_issue_queue_integer;
   localparam int DW = 32;
   localparam int TW = 6;
   localparam int OW = 4;
   localparam int DEPTH = 4;
`ifdef IQ_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   issue_queue_integer_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OPCODE_WIDTH(OW)) iq ();

   issue_queue_integer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OPCODE_WIDTH(OW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .iq    (iq)
   );

   typedef struct {
      logic [OW-1:0] op;
      logic [TW-1:0] rd;
      logic [TW-1:0] t1;
      logic [TW-1:0] t2;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      bit            v1;
      bit            v2;
   } ent_t;

   ent_t q[$];
   int vectors = 0;
   int miscompares = 0;
   logic          s_valid, s_full;
   logic [OW-1:0] s_op;
   logic [TW-1:0] s_rd;
   logic [DW-1:0] s_d1, s_d2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit op_ready(input bit v, input logic [TW-1:0] t);
      return v || (BYP && iq.CDB_valid && (t == iq.CDB_tag));
   endfunction

   function automatic ent_t wake(input ent_t e, input bit cv, input logic [TW-1:0] ct,
                                 input logic [DW-1:0] cd);
      ent_t r;
      r = e;
      if (cv && !r.v1 && r.t1 == ct) begin r.v1 = 1'b1; r.d1 = cd; end
      if (cv && !r.v2 && r.t2 == ct) begin r.v2 = 1'b1; r.d2 = cd; end
      return r;
   endfunction

   task automatic drive_disp(input bit en, input logic [OW-1:0] op, input logic [TW-1:0] rd,
                             input logic [DW-1:0] d1, input logic [TW-1:0] t1, input bit v1,
                             input logic [DW-1:0] d2, input logic [TW-1:0] t2, input bit v2);
      iq.dispatch_en_integer = en;
      iq.dispatch_opcode     = op;
      iq.dispatch_rd_tag     = rd;
      iq.dispatch_rs1_data   = d1;
      iq.dispatch_rs1_tag    = t1;
      iq.dispatch_rs1_valid  = v1;
      iq.dispatch_rs2_data   = d2;
      iq.dispatch_rs2_tag    = t2;
      iq.dispatch_rs2_valid  = v2;
   endtask

   task automatic idle_disp();
      drive_disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
   endtask

   task automatic drive_cdb(input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      iq.CDB_valid = v;
      iq.CDB_tag   = t;
      iq.CDB_data  = d;
   endtask

   // One clock: predict outputs, sample mid-cycle, compare, then advance the model at the edge.
   task automatic cycle();
      bit fnd, fire, accept, cv;
      int idx;
      logic [DW-1:0] e1, e2, cd;
      logic [TW-1:0] ct;
      ent_t n;
      fnd = 1'b0; idx = 0; e1 = '0; e2 = '0;
      foreach (q[i]) begin
         if (!fnd && op_ready(q[i].v1, q[i].t1) && op_ready(q[i].v2, q[i].t2)) begin
            fnd = 1'b1; idx = i;
         end
      end
      if (fnd) begin
         e1 = q[idx].v1 ? q[idx].d1 : iq.CDB_data;
         e2 = q[idx].v2 ? q[idx].d2 : iq.CDB_data;
      end
      #4;
      s_valid = iq.issue_valid; s_full = iq.issueque_full_integer;
      s_op = iq.issue_opcode; s_rd = iq.issue_rd_tag;
      s_d1 = iq.issue_rs1_data; s_d2 = iq.issue_rs2_data;
      chk("issue_valid", s_valid, fnd);
      chk("full", s_full, q.size() == DEPTH);
      chk("issue_opcode", s_op, fnd ? q[idx].op : '0);
      chk("issue_rd_tag", s_rd, fnd ? q[idx].rd : '0);
      chk("issue_rs1_data", s_d1, e1);
      chk("issue_rs2_data", s_d2, e2);
      fire   = fnd && iq.issue_ready;
      accept = iq.dispatch_en_integer && (q.size() < DEPTH);
      cv = iq.CDB_valid; ct = iq.CDB_tag; cd = iq.CDB_data;
      n.op = iq.dispatch_opcode; n.rd = iq.dispatch_rd_tag;
      n.t1 = iq.dispatch_rs1_tag; n.d1 = iq.dispatch_rs1_data; n.v1 = iq.dispatch_rs1_valid;
      n.t2 = iq.dispatch_rs2_tag; n.d2 = iq.dispatch_rs2_data; n.v2 = iq.dispatch_rs2_valid;
      if (!reset && iq.dispatch_en_integer && !accept)
         $display("note: dispatch while full at %0t (protocol error, op dropped)", $time);
      @(posedge clk);
      if (reset) begin
         q.delete();
      end else begin
         if (fire) q.delete(idx);
         foreach (q[i]) q[i] = wake(q[i], cv, ct, cd);
         if (accept) q.push_back(wake(n, cv, ct, cd));
      end
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle_disp();
      drive_cdb(1'b0, 6'd0, 32'd0);
      iq.issue_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset then idle
      repeat (10) begin
         cycle();
         chk("idle_valid", s_valid, 1'b0);
         chk("idle_full", s_full, 1'b0);
      end

      // Ready op presented the cycle after dispatch
      iq.issue_ready = 1'b1;
      drive_disp(1'b1, 4'h3, 6'd5, 32'd7, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1);
      cycle();
      idle_disp();
      cycle();
      chk("ready_valid", s_valid, 1'b1);
      chk("ready_opcode", s_op, 4'h3);
      chk("ready_rd", s_rd, 6'd5);
      chk("ready_rs1", s_d1, 32'd7);
      chk("ready_rs2", s_d2, 32'd9);
      cycle();
      chk("ready_empty", s_valid, 1'b0);

      // CDB wakeup of rs1
      drive_disp(1'b1, 4'h6, 6'd1, 32'd0, 6'd12, 1'b0, 32'd4, 6'd0, 1'b1);
      cycle();
      idle_disp();
      drive_cdb(1'b1, 6'd12, 32'hDEAD);
      cycle();
      chk("wake_n_valid", s_valid, BYP);
      chk("wake_n_rs1", s_d1, BYP ? 32'hDEAD : 32'h0);
      drive_cdb(1'b0, 6'd0, 32'd0);
      cycle();
      chk("wake_n1_valid", s_valid, !BYP);
      chk("wake_n1_rs1", s_d1, BYP ? 32'h0 : 32'hDEAD);

      // Fill to full, drop a fifth dispatch, drain in order
      iq.issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_disp(1'b1, OW'(k + 1), TW'(k + 8), 32'(100 + k), 6'd0, 1'b1, 32'(200 + k), 6'd0, 1'b1);
         cycle();
      end
      drive_disp(1'b1, 4'hF, 6'd63, 32'd999, 6'd0, 1'b1, 32'd999, 6'd0, 1'b1);
      cycle();
      chk("full_after_4", s_full, 1'b1);
      idle_disp();
      iq.issue_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("drain_op", s_op, OW'(k + 1));
         chk("drain_rs1", s_d1, 32'(100 + k));
      end
      cycle();
      chk("drain_empty", s_valid, 1'b0);
      chk("drain_notfull", s_full, 1'b0);

      // Dispatch+issue at count 3 and at count 4
      iq.issue_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_disp(1'b1, OW'(k + 1), 6'd2, 32'(k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
         cycle();
      end
      drive_disp(1'b1, 4'h4, 6'd2, 32'd3, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
      iq.issue_ready = 1'b1;
      cycle();
      idle_disp();
      iq.issue_ready = 1'b0;
      cycle();
      chk("cnt3_notfull", s_full, 1'b0);
      chk("cnt3_head", s_op, 4'h2);
      drive_disp(1'b1, 4'h5, 6'd2, 32'd4, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
      cycle();
      drive_disp(1'b1, 4'h6, 6'd2, 32'd5, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
      iq.issue_ready = 1'b1;
      cycle();
      chk("cnt4_full", s_full, 1'b1);
      idle_disp();
      iq.issue_ready = 1'b0;
      cycle();
      chk("cnt4_to3_notfull", s_full, 1'b0);
      chk("cnt4_to3_head", s_op, 4'h3);
      iq.issue_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("cnt_drain_op", s_op, OW'(k + 3));
      end
      cycle();
      chk("cnt_drain_empty", s_valid, 1'b0);

      // Dispatch-cycle CDB capture on rs2
      iq.issue_ready = 1'b0;
      drive_disp(1'b1, 4'h7, 6'd9, 32'd11, 6'd0, 1'b1, 32'd0, 6'd20, 1'b0);
      drive_cdb(1'b1, 6'd20, 32'h1234);
      cycle();
      idle_disp();
      drive_cdb(1'b0, 6'd0, 32'd0);
      cycle();
      chk("capture_valid", s_valid, 1'b1);
      chk("capture_rs1", s_d1, 32'd11);
      chk("capture_rs2", s_d2, 32'h1234);
      iq.issue_ready = 1'b1;
      cycle();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 1 && q.size() < DEPTH)
            drive_disp(1'b1, OW'($urandom), TW'($urandom), $urandom, TW'($urandom_range(0, 7)),
                       $urandom_range(0, 2) != 0, $urandom, TW'($urandom_range(0, 7)),
                       $urandom_range(0, 2) != 0);
         else
            idle_disp();
         drive_cdb($urandom_range(0, 1) == 1, TW'($urandom_range(0, 7)), $urandom);
         iq.issue_ready = $urandom_range(0, 3) != 0;
         cycle();
      end

      // Mid-drain reset
      idle_disp();
      drive_cdb(1'b0, 6'd0, 32'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      iq.issue_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_disp(1'b1, OW'(k + 9), 6'd3, 32'(k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
         cycle();
      end
      idle_disp();
      iq.issue_ready = 1'b1;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_full", s_full, 1'b0);
      chk("rst_opcode", s_op, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
